// File: rtl/ascon_pkg.sv
// Shared constants and FSM state type for the Ascon tag-verification stage.
package ascon_pkg;

    localparam int TAG_W     = 128;
    localparam int DEFAULT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

endpackage

// File: rtl/ascon_rise_detect.sv
// Registered rising-edge detector: rise is high for the first cycle d is seen high.
module ascon_rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic dr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dr_q <= 1'b0;
        end else begin
            dr_q <= d;
        end
    end

    assign rise = d & ~dr_q;

endmodule

// File: rtl/ascon_tag_verify.sv
// Tag verification and gated plaintext release after masked Ascon decryption.
// Define ASCON_TAG_CONST_TIME_EN to always compare all chunks (fixed verdict latency).
module ascon_tag_verify
    import ascon_pkg::*;
#(
    parameter int y = 40,
    parameter int W = DEFAULT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             decryption_ready,
    input  logic [y-1:0]     plain_text,
    input  logic [TAG_W-1:0] tag,
    input  logic [TAG_W-1:0] expected_tag,
    input  logic             pt_ready,
    output logic [y-1:0]     pt_out,
    output logic             pt_valid,
    output logic             verdict_valid,
    output logic             tag_match,
    output logic             busy
);

    localparam int N     = TAG_W / W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t             state_q, state_d;
    logic               start;
    logic [y-1:0]       pt_q;
    logic [TAG_W-1:0]   tag_q, exp_q;
    logic [IDX_W-1:0]   idx_q;
    logic               diff_q;
    logic               tag_match_q;
    logic               verdict_q;
    logic               chunk_diff, diff_now, last_chunk, finish;
    logic               capture, done, release_done;

    ascon_rise_detect u_rise (
        .clk  (clk),
        .rst  (rst),
        .d    (decryption_ready),
        .rise (start)
    );

    // Tag registers shift left each compare cycle so the active chunk is always the top W bits.
    assign chunk_diff = |(tag_q[TAG_W-1 -: W] ^ exp_q[TAG_W-1 -: W]);
    assign diff_now   = diff_q | chunk_diff;
    assign last_chunk = (idx_q == LAST_IDX);

`ifdef ASCON_TAG_CONST_TIME_EN
    assign finish = last_chunk;
`else
    assign finish = last_chunk | chunk_diff;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        capture      = 1'b0;
        done         = 1'b0;
        release_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    capture = 1'b1;
                    state_d = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (finish) begin
                    done    = 1'b1;
                    state_d = diff_now ? ST_IDLE : ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (pt_ready) begin
                    release_done = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Secrets are wiped as soon as they are no longer needed: tags at the verdict,
    // plaintext on a failed verdict or once the consumer has taken it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pt_q        <= '0;
            tag_q       <= '0;
            exp_q       <= '0;
            idx_q       <= '0;
            diff_q      <= 1'b0;
            tag_match_q <= 1'b0;
            verdict_q   <= 1'b0;
        end else begin
            verdict_q <= 1'b0;
            if (capture) begin
                pt_q        <= plain_text;
                tag_q       <= tag;
                exp_q       <= expected_tag;
                idx_q       <= '0;
                diff_q      <= 1'b0;
                tag_match_q <= 1'b0;
            end else if (done) begin
                verdict_q   <= 1'b1;
                tag_match_q <= ~diff_now;
                tag_q       <= '0;
                exp_q       <= '0;
                idx_q       <= '0;
                diff_q      <= 1'b0;
                if (diff_now) begin
                    pt_q <= '0;
                end
            end else if (state_q == ST_COMPARE) begin
                tag_q  <= tag_q << W;
                exp_q  <= exp_q << W;
                idx_q  <= idx_q + IDX_W'(1);
                diff_q <= diff_now;
            end else if (release_done) begin
                pt_q <= '0;
            end
        end
    end

    assign busy          = (state_q != ST_IDLE);
    assign pt_valid      = (state_q == ST_RELEASE);
    assign pt_out        = pt_valid ? pt_q : '0;
    assign verdict_valid = verdict_q;
    assign tag_match     = tag_match_q;

endmodule

// File: tb/tb_ascon_tag_verify.sv
// Directed self-checking bench for ascon_tag_verify (W=32, N=4).
module tb_ascon_tag_verify;

    localparam logic [127:0] T  = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [39:0]  PT = 40'hA5A5A5A5A5;

`ifdef ASCON_TAG_CONST_TIME_EN
    localparam int FIRST_FAIL_CYCLE = 5;
`else
    localparam int FIRST_FAIL_CYCLE = 2;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          decryption_ready;
    logic [39:0]   plain_text;
    logic [127:0]  tag;
    logic [127:0]  expected_tag;
    logic          pt_ready;
    logic [39:0]   pt_out;
    logic          pt_valid;
    logic          verdict_valid;
    logic          tag_match;
    logic          busy;

    int tests_run    = 0;
    int tests_failed = 0;

    ascon_tag_verify #(.y(40), .W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .decryption_ready (decryption_ready),
        .plain_text       (plain_text),
        .tag              (tag),
        .expected_tag     (expected_tag),
        .pt_ready         (pt_ready),
        .pt_out           (pt_out),
        .pt_valid         (pt_valid),
        .verdict_valid    (verdict_valid),
        .tag_match        (tag_match),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts one verification in the current cycle C and observes C+1..C+cycles.
    task automatic run_verify(input logic [127:0] et, input logic rdy, input int cycles,
                              input int hold, output int vcycle, output int vcount,
                              output logic vmatch, output int leak);
        tag = T; expected_tag = et; plain_text = PT; pt_ready = rdy;
        decryption_ready = 1'b1;
        vcycle = -1; vcount = 0; vmatch = 1'bx; leak = 0;
        for (int c = 1; c <= cycles; c++) begin
            tick();
            if (c >= hold) decryption_ready = 1'b0;
            if (verdict_valid === 1'b1) begin
                vcount++;
                if (vcycle < 0) begin
                    vcycle = c;
                    vmatch = tag_match;
                end
            end
            if (pt_valid !== 1'b0 || pt_out !== 40'h0) leak++;
        end
        decryption_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; decryption_ready = 1'b0; plain_text = '0; tag = '0;
        expected_tag = '0; pt_ready = 1'b0;
        tick(); tick();
        tests_run++; if (pt_out !== 40'h0) begin tests_failed++; $display("[TB] FAIL reset_pt_out: got %h expected 0", pt_out); end
        tests_run++; if ({pt_valid, verdict_valid, tag_match, busy} !== 4'b0) begin tests_failed++; $display("[TB] FAIL reset_flags: got %b expected 0000", {pt_valid, verdict_valid, tag_match, busy}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_pass();
        int vc;
        tag = T; expected_tag = T; plain_text = PT; pt_ready = 1'b1;
        decryption_ready = 1'b1;
        vc = 0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            decryption_ready = 1'b0;
            if (verdict_valid === 1'b1 || pt_valid === 1'b1) vc++;
        end
        tests_run++; if (vc !== 0) begin tests_failed++; $display("[TB] FAIL pass_early_output: got %0d expected 0", vc); end
        tick();
        tests_run++; if ({verdict_valid, tag_match, pt_valid} !== 3'b111) begin tests_failed++; $display("[TB] FAIL pass_verdict_c5: got %b expected 111", {verdict_valid, tag_match, pt_valid}); end
        tests_run++; if (pt_out !== PT) begin tests_failed++; $display("[TB] FAIL pass_pt_out_c5: got %h expected %h", pt_out, PT); end
        tick();
        tests_run++; if (pt_out !== 40'h0 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL pass_done_c6: got pt_out=%h busy=%b expected 0/0", pt_out, busy); end
        tests_run++; if (tag_match !== 1'b1 || verdict_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL pass_hold_c6: got match=%b verdict=%b expected 1/0", tag_match, verdict_valid); end
        tick();
    endtask

    task automatic test_fail_first();
        int vcy, vcn, lk; logic vm;
        run_verify(T ^ (128'h1 << 127), 1'b1, 8, 1, vcy, vcn, vm, lk);
        tests_run++; if (vcy !== FIRST_FAIL_CYCLE) begin tests_failed++; $display("[TB] FAIL fail_first_latency: got %0d expected %0d", vcy, FIRST_FAIL_CYCLE); end
        tests_run++; if (vcn !== 1 || vm !== 1'b0) begin tests_failed++; $display("[TB] FAIL fail_first_verdict: got count=%0d match=%b expected 1/0", vcn, vm); end
        tests_run++; if (lk !== 0) begin tests_failed++; $display("[TB] FAIL fail_first_leak: got %0d expected 0", lk); end
    endtask

    task automatic test_fail_last();
        int vcy, vcn, lk; logic vm;
        run_verify(T ^ 128'h1, 1'b1, 8, 1, vcy, vcn, vm, lk);
        tests_run++; if (vcy !== 5) begin tests_failed++; $display("[TB] FAIL fail_last_latency: got %0d expected 5", vcy); end
        tests_run++; if (vcn !== 1 || vm !== 1'b0) begin tests_failed++; $display("[TB] FAIL fail_last_verdict: got count=%0d match=%b expected 1/0", vcn, vm); end
        tests_run++; if (lk !== 0) begin tests_failed++; $display("[TB] FAIL fail_last_leak: got %0d expected 0", lk); end
    endtask

    task automatic test_backpressure();
        int bad, vcn;
        tag = T; expected_tag = T; plain_text = PT; pt_ready = 1'b0;
        decryption_ready = 1'b1;
        tick();
        decryption_ready = 1'b0;
        for (int c = 2; c <= 5; c++) tick();
        tests_run++; if ({verdict_valid, pt_valid} !== 2'b11 || pt_out !== PT) begin tests_failed++; $display("[TB] FAIL bp_first_valid: got v=%b pv=%b pt=%h expected 1/1/%h", verdict_valid, pt_valid, pt_out, PT); end
        bad = 0; vcn = 0;
        for (int s = 0; s < 10; s++) begin
            if (pt_valid !== 1'b1 || pt_out !== PT) bad++;
            if (s > 0 && verdict_valid === 1'b1) vcn++;
            if (s == 2) decryption_ready = 1'b1;
            if (s == 3) decryption_ready = 1'b0;
            tick();
        end
        tests_run++; if (bad !== 0) begin tests_failed++; $display("[TB] FAIL bp_stall_hold: got %0d bad cycles expected 0", bad); end
        pt_ready = 1'b1;
        tests_run++; if (pt_valid !== 1'b1 || pt_out !== PT) begin tests_failed++; $display("[TB] FAIL bp_transfer_cycle: got pv=%b pt=%h expected 1/%h", pt_valid, pt_out, PT); end
        tick();
        tests_run++; if (pt_valid !== 1'b0 || busy !== 1'b0 || pt_out !== 40'h0) begin tests_failed++; $display("[TB] FAIL bp_after_transfer: got pv=%b busy=%b pt=%h expected 0/0/0", pt_valid, busy, pt_out); end
        for (int c = 0; c < 8; c++) begin
            tick();
            if (verdict_valid === 1'b1 || busy === 1'b1) vcn++;
        end
        tests_run++; if (vcn !== 0) begin tests_failed++; $display("[TB] FAIL bp_repulse_ignored: got %0d extra events expected 0", vcn); end
    endtask

    task automatic test_reset_mid();
        int vcy, vcn, lk, stray; logic vm;
        tag = T; expected_tag = T; plain_text = PT; pt_ready = 1'b1;
        decryption_ready = 1'b1;
        tick();
        decryption_ready = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #1;
        tests_run++; if ({pt_valid, verdict_valid, tag_match, busy} !== 4'b0 || pt_out !== 40'h0) begin tests_failed++; $display("[TB] FAIL mid_reset_outputs: got flags=%b pt=%h expected 0000/0", {pt_valid, verdict_valid, tag_match, busy}, pt_out); end
        tick();
        rst = 1'b0;
        stray = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (verdict_valid === 1'b1 || busy === 1'b1) stray++;
        end
        tests_run++; if (stray !== 0) begin tests_failed++; $display("[TB] FAIL mid_reset_no_verdict: got %0d events expected 0", stray); end
        run_verify(T, 1'b1, 7, 1, vcy, vcn, vm, lk);
        tests_run++; if (vcy !== 5 || vm !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_reset_restart: got cycle=%0d match=%b expected 5/1", vcy, vm); end
    endtask

    task automatic test_held_high();
        int vcy, vcn, lk; logic vm;
        run_verify(T, 1'b1, 50, 50, vcy, vcn, vm, lk);
        tests_run++; if (vcn !== 1 || vcy !== 5) begin tests_failed++; $display("[TB] FAIL held_high_single: got count=%0d cycle=%0d expected 1/5", vcn, vcy); end
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail_first();
        test_fail_last();
        test_backpressure();
        test_reset_mid();
        test_held_high();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
